// File: rtl/pim_addr_arb.sv
`default_nettype none
// ============================================================================
// Module      : pim_addr_arb
// Description : Round-robin arbiter sharing one MPMC PIM address channel among
//               C_NUM_REQ requesters, with an in-order read-owner queue that
//               steers returning read data. Define PIM_ARB_FIXED_PRIO_EN for
//               fixed priority (lowest eligible index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module pim_addr_arb #(
    parameter int C_NUM_REQ   = 2,
    parameter int C_ID_W      = 1,
    parameter int C_RDQ_DEPTH = 4
) (
    input  logic                     MPMC_Clk,
    input  logic                     MPMC_Rst,
    input  logic [C_NUM_REQ-1:0]     req_valid,
    input  logic [32*C_NUM_REQ-1:0]  req_addr,
    input  logic [C_NUM_REQ-1:0]     req_rnw,
    input  logic [C_NUM_REQ-1:0]     req_rmw,
    input  logic [4*C_NUM_REQ-1:0]   req_size,
    output logic [C_NUM_REQ-1:0]     req_ack,
    output logic [31:0]              PIM_Addr,
    output logic                     PIM_AddrReq,
    output logic                     PIM_RNW,
    output logic                     PIM_RdModWr,
    output logic [3:0]               PIM_Size,
    input  logic                     PIM_AddrAck,
    output logic [C_ID_W-1:0]        rd_owner,
    output logic                     rd_owner_valid,
    input  logic                     rd_done,
    output logic                     rd_err
);

    localparam int PTR_W = (C_RDQ_DEPTH > 1) ? $clog2(C_RDQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(C_RDQ_DEPTH) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [C_ID_W-1:0]   grant_q, grant_d;
    logic [31:0]         addr_q, addr_d;
    logic                rnw_q, rnw_d;
    logic                rmw_q, rmw_d;
    logic [3:0]          size_q, size_d;
    logic [C_ID_W-1:0]   rdq_q [C_RDQ_DEPTH];
    logic [C_ID_W-1:0]   rdq_d [C_RDQ_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                rd_err_q, rd_err_d;

    logic                rdq_full;
    logic                rdq_empty;
    logic                push;
    logic                pop;
    logic [C_NUM_REQ-1:0] eligible;
    logic                pick_found;
    logic [C_ID_W-1:0]   pick_idx;
    logic [31:0]         pick_addr;
    logic                pick_rnw;
    logic                pick_rmw;
    logic [3:0]          pick_size;

`ifdef PIM_ARB_FIXED_PRIO_EN
`else
    logic [C_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    assign rdq_full  = (count_q == CNT_W'(C_RDQ_DEPTH));
    assign rdq_empty = (count_q == '0);
    assign eligible  = req_valid & ~(req_rnw & {C_NUM_REQ{rdq_full}});

    // Scan from the search base upward with wrap; first eligible index wins.
    always_comb begin
        int base;
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_addr  = '0;
        pick_rnw   = 1'b0;
        pick_rmw   = 1'b0;
        pick_size  = '0;
        idx        = 0;
`ifdef PIM_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = int'(rr_ptr_q);
`endif
        for (int k = 0; k < C_NUM_REQ; k++) begin
            idx = base + k;
            if (idx >= C_NUM_REQ) begin
                idx = idx - C_NUM_REQ;
            end
            if (!pick_found && eligible[idx]) begin
                pick_found = 1'b1;
                pick_idx   = C_ID_W'(idx);
                pick_addr  = req_addr[32*idx +: 32];
                pick_rnw   = req_rnw[idx];
                pick_rmw   = req_rmw[idx];
                pick_size  = req_size[4*idx +: 4];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        rnw_d    = rnw_q;
        rmw_d    = rmw_q;
        size_d   = size_q;
        req_ack  = '0;
        push     = 1'b0;
`ifdef PIM_ARB_FIXED_PRIO_EN
`else
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_REQ;
                    grant_d = pick_idx;
                    addr_d  = pick_addr;
                    rnw_d   = pick_rnw;
                    rmw_d   = pick_rmw;
                    size_d  = pick_size;
                end
            end
            ST_REQ: begin
                if (PIM_AddrAck) begin
                    for (int i = 0; i < C_NUM_REQ; i++) begin
                        if (grant_q == C_ID_W'(i)) begin
                            req_ack[i] = 1'b1;
                        end
                    end
                    push    = rnw_q;
                    state_d = ST_IDLE;
`ifdef PIM_ARB_FIXED_PRIO_EN
`else
                    rr_ptr_d = (grant_q == C_ID_W'(C_NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Owner queue: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        rdq_d    = rdq_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = rd_done & ~rdq_empty;
        rd_err_d = rd_err_q | (rd_done & rdq_empty);
        if (push) begin
            rdq_d[wr_ptr_q] = grant_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge MPMC_Clk or posedge MPMC_Rst) begin
        if (MPMC_Rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            addr_q   <= '0;
            rnw_q    <= 1'b0;
            rmw_q    <= 1'b0;
            size_q   <= '0;
            rdq_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            rnw_q    <= rnw_d;
            rmw_q    <= rmw_d;
            size_q   <= size_d;
            rdq_q    <= rdq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rd_err_q <= rd_err_d;
        end
    end

`ifdef PIM_ARB_FIXED_PRIO_EN
`else
    always_ff @(posedge MPMC_Clk or posedge MPMC_Rst) begin
        if (MPMC_Rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign PIM_AddrReq    = (state_q == ST_REQ);
    assign PIM_Addr       = addr_q;
    assign PIM_RNW        = rnw_q;
    assign PIM_RdModWr    = rmw_q;
    assign PIM_Size       = size_q;
    assign rd_owner       = rdq_q[rd_ptr_q];
    assign rd_owner_valid = ~rdq_empty;
    assign rd_err         = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pim_addr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pim_addr_arb
// Description : Directed self-checking bench for pim_addr_arb (2 requesters,
//               4-deep read-owner queue, round-robin build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pim_addr_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic [1:0]  req_rnw;
    logic [1:0]  req_rmw;
    logic [7:0]  req_size;
    logic [1:0]  req_ack;
    logic [31:0] pim_addr;
    logic        pim_addr_req;
    logic        pim_rnw;
    logic        pim_rmw;
    logic [3:0]  pim_size;
    logic        pim_addr_ack;
    logic [0:0]  rd_owner;
    logic        rd_owner_valid;
    logic        rd_done;
    logic        rd_err;

    int n_checks = 0;
    int n_errors = 0;

    pim_addr_arb #(
        .C_NUM_REQ   (2),
        .C_ID_W      (1),
        .C_RDQ_DEPTH (4)
    ) u_dut (
        .MPMC_Clk       (clk),
        .MPMC_Rst       (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_rnw        (req_rnw),
        .req_rmw        (req_rmw),
        .req_size       (req_size),
        .req_ack        (req_ack),
        .PIM_Addr       (pim_addr),
        .PIM_AddrReq    (pim_addr_req),
        .PIM_RNW        (pim_rnw),
        .PIM_RdModWr    (pim_rmw),
        .PIM_Size       (pim_size),
        .PIM_AddrAck    (pim_addr_ack),
        .rd_owner       (rd_owner),
        .rd_owner_valid (rd_owner_valid),
        .rd_done        (rd_done),
        .rd_err         (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) for the address request, ack it, and check who was granted.
    task automatic grant_cycle(input string tag, input logic [1:0] exp_ack,
                               input logic [31:0] exp_addr, input logic exp_rnw,
                               input logic done_with_ack);
        int n;
        n = 0;
        while (!pim_addr_req && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {31'd0, pim_addr_req}, 32'd1);
        pim_addr_ack = 1'b1;
        rd_done      = done_with_ack;
        #1;
        chk({tag, "_ack"},  {30'd0, req_ack}, {30'd0, exp_ack});
        chk({tag, "_addr"}, pim_addr, exp_addr);
        chk({tag, "_rnw"},  {31'd0, pim_rnw}, {31'd0, exp_rnw});
        tick();
        pim_addr_ack = 1'b0;
        rd_done      = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 2'b11;
        req_addr     = '0;
        req_rnw      = '0;
        req_rmw      = '0;
        req_size     = '0;
        pim_addr_ack = 1'b0;
        rd_done      = 1'b0;

        // T1: reset holds everything quiet even with both requesting
        tick();
        tick();
        chk("t1_addrreq", {31'd0, pim_addr_req}, 32'd0);
        chk("t1_ack",     {30'd0, req_ack}, 32'd0);
        chk("t1_rdvalid", {31'd0, rd_owner_valid}, 32'd0);
        chk("t1_rderr",   {31'd0, rd_err}, 32'd0);
        chk("t1_addr",    pim_addr, 32'd0);
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        tick();

        // Ack while idle must be ignored
        pim_addr_ack = 1'b1;
        #1;
        chk("idle_ack_ignored", {30'd0, req_ack}, 32'd0);
        tick();
        pim_addr_ack = 1'b0;
        chk("idle_no_req", {31'd0, pim_addr_req}, 32'd0);

        // T2: single write, acked 3 cycles after AddrReq
        req_valid       = 2'b01;
        req_addr[31:0]  = 32'h0000_1000;
        req_rnw[0]      = 1'b0;
        req_size[3:0]   = 4'h2;
        tick();
        chk("t2_req",  {31'd0, pim_addr_req}, 32'd1);
        chk("t2_addr", pim_addr, 32'h0000_1000);
        chk("t2_size", {28'd0, pim_size}, 32'h2);
        chk("t2_rnw",  {31'd0, pim_rnw}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t2_hold_addr", pim_addr, 32'h0000_1000);
            chk("t2_hold_noack", {30'd0, req_ack}, 32'd0);
        end
        tick();
        pim_addr_ack = 1'b1;
        #1;
        chk("t2_ack", {30'd0, req_ack}, 32'd1);
        tick();
        pim_addr_ack = 1'b0;
        req_valid    = 2'b00;
        #1;
        chk("t2_ack_once", {30'd0, req_ack}, 32'd0);
        chk("t2_req_drop", {31'd0, pim_addr_req}, 32'd0);
        chk("t2_q_empty",  {31'd0, rd_owner_valid}, 32'd0);

        // T3: both writing continuously; rr pointer is 1 after T2's grant to 0
        req_addr  = {32'h0000_B000, 32'h0000_A000};
        req_rnw   = 2'b00;
        req_valid = 2'b11;
        grant_cycle("t3_g0", 2'b10, 32'h0000_B000, 1'b0, 1'b0);
        grant_cycle("t3_g1", 2'b01, 32'h0000_A000, 1'b0, 1'b0);
        grant_cycle("t3_g2", 2'b10, 32'h0000_B000, 1'b0, 1'b0);
        grant_cycle("t3_g3", 2'b01, 32'h0000_A000, 1'b0, 1'b0);
        chk("t3_q_empty", {31'd0, rd_owner_valid}, 32'd0);

        // T4: fill the owner queue with reads from requester 1
        req_valid = 2'b10;
        req_rnw   = 2'b10;
        for (int r = 0; r < 4; r++) begin
            req_addr[63:32] = 32'h0000_2000 + 32'(r * 16);
            grant_cycle("t4_rd", 2'b10, 32'h0000_2000 + 32'(r * 16), 1'b1, 1'b0);
        end
        req_addr[63:32] = 32'h0000_2040;
        chk("t4_owner",   {31'd0, rd_owner}, 32'd1);
        chk("t4_ovalid",  {31'd0, rd_owner_valid}, 32'd1);
        tick();
        chk("t4_full_block0", {31'd0, pim_addr_req}, 32'd0);
        tick();
        chk("t4_full_block1", {31'd0, pim_addr_req}, 32'd0);
        req_addr[31:0] = 32'h0000_3000;
        req_valid      = 2'b11;
        grant_cycle("t4_wr", 2'b01, 32'h0000_3000, 1'b0, 1'b0);
        req_valid = 2'b10;
        rd_done   = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t4_pop_cycle_noreq", {31'd0, pim_addr_req}, 32'd0);
        tick();
        chk("t4_rd_after_pop", {31'd0, pim_addr_req}, 32'd1);
        grant_cycle("t4_rd5", 2'b10, 32'h0000_2040, 1'b1, 1'b0);
        req_valid = 2'b00;

        // Drain exactly four entries
        rd_done = 1'b1;
        repeat (4) tick();
        rd_done = 1'b0;
        chk("drain_empty", {31'd0, rd_owner_valid}, 32'd0);
        chk("drain_noerr", {31'd0, rd_err}, 32'd0);

        // T5: queue [0,1], then push 0 while popping head
        req_rnw         = 2'b11;
        req_addr[31:0]  = 32'h0000_4000;
        req_valid       = 2'b01;
        grant_cycle("t5_rd0", 2'b01, 32'h0000_4000, 1'b1, 1'b0);
        req_addr[63:32] = 32'h0000_5000;
        req_valid       = 2'b10;
        chk("t5_head0", {31'd0, rd_owner}, 32'd0);
        grant_cycle("t5_rd1", 2'b10, 32'h0000_5000, 1'b1, 1'b0);
        req_addr[31:0]  = 32'h0000_6000;
        req_valid       = 2'b01;
        grant_cycle("t5_rd2", 2'b01, 32'h0000_6000, 1'b1, 1'b1);
        req_valid = 2'b00;
        chk("t5_head_adv", {31'd0, rd_owner}, 32'd1);
        chk("t5_valid2",   {31'd0, rd_owner_valid}, 32'd1);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t5_appended", {31'd0, rd_owner}, 32'd0);
        chk("t5_valid1",   {31'd0, rd_owner_valid}, 32'd1);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t5_empty", {31'd0, rd_owner_valid}, 32'd0);
        chk("t5_noerr", {31'd0, rd_err}, 32'd0);

        // T6: underflow is sticky, reset during REQ clears asynchronously
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t6_err", {31'd0, rd_err}, 32'd1);
        tick();
        chk("t6_err_sticky", {31'd0, rd_err}, 32'd1);
        req_rnw        = 2'b00;
        req_addr[31:0] = 32'h0000_7000;
        req_valid      = 2'b01;
        tick();
        chk("t6_in_req", {31'd0, pim_addr_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_drop", {31'd0, pim_addr_req}, 32'd0);
        chk("t6_err_clr",    {31'd0, rd_err}, 32'd0);
        chk("t6_addr_clr",   pim_addr, 32'd0);
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_idle", {31'd0, pim_addr_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
